// File: rtl/fpaddsub_pkg.sv
// fpaddsub_pkg: shared constants for the FP add/sub issue path.
package fpaddsub_pkg;

    localparam int unsigned FP_W   = 32;
    // Depth of the current FPAddSub pipeline, fu_valid to fu_res.
    localparam int unsigned FP_LAT = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Map a requester op bit onto the unit's OpMode encoding.
    function automatic logic op_mode(input logic sub);
        return sub ? OP_SUB : OP_ADD;
    endfunction

endpackage

// File: rtl/fpaddsub_rr_arbiter.sv
// fpaddsub_rr_arbiter: combinational N-way round-robin grant.
// Searches upward from ptr with wrap; hold forces an all-zero grant.
module fpaddsub_rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned TW = 2
) (
    input  logic [N-1:0]  valid,
    input  logic [TW-1:0] ptr,
    input  logic          hold,
    output logic [N-1:0]  grant,
    output logic [TW-1:0] grant_idx,
    output logic          found
);

    // First pass covers indices at or above ptr, second pass wraps to the rest.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        if (!hold) begin
            for (int i = 0; i < int'(N); i++) begin
                if (!found && valid[i] && (TW'(i) >= ptr)) begin
                    grant[i]  = 1'b1;
                    grant_idx = TW'(i);
                    found     = 1'b1;
                end
            end
            for (int i = 0; i < int'(N); i++) begin
                if (!found && valid[i]) begin
                    grant[i]  = 1'b1;
                    grant_idx = TW'(i);
                    found     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fpaddsub_issue_arbiter.sv
// fpaddsub_issue_arbiter: shares one fixed-latency FP add/sub unit among N
// requesters. Round-robin grant, registered issue, tag pipe to route each
// result back to its owner, in-flight counter for idle.
// Optional: FPADDSUB_ARB_PERF_EN adds saturating perf_issue/perf_conflict.
module fpaddsub_issue_arbiter
    import fpaddsub_pkg::*;
#(
    parameter int unsigned N   = 4,
    parameter int unsigned W   = FP_W,
    parameter int unsigned LAT = FP_LAT,
    parameter int unsigned TW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req_valid,
    output logic [N-1:0]   req_ready,
    input  logic [N*W-1:0] req_a,
    input  logic [N*W-1:0] req_b,
    input  logic [N-1:0]   req_op,
    input  logic           hold,
    output logic           fu_valid,
    output logic [W-1:0]   fu_a,
    output logic [W-1:0]   fu_b,
    output logic           fu_op,
    input  logic [W-1:0]   fu_res,
    output logic [N-1:0]   res_valid,
    output logic [W-1:0]   res_data,
    output logic [TW-1:0]  res_tag,
    output logic           idle
`ifdef FPADDSUB_ARB_PERF_EN
    ,
    output logic [31:0]    perf_issue,
    output logic [31:0]    perf_conflict
`endif
);

    localparam int unsigned CW = $clog2(LAT + 3);

    logic [TW-1:0]  ptr_q;
    logic [TW-1:0]  grant_idx;
    logic           accept;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    logic           sel_op;
    logic [TW-1:0]  tag_q;
    logic [LAT-1:0] pipe_v_q;
    logic [TW-1:0]  pipe_tag_q [LAT];
    logic [N-1:0]   ret_onehot;
    logic [CW-1:0]  inflight_q;
    logic           strobe;

    fpaddsub_rr_arbiter #(
        .N  (N),
        .TW (TW)
    ) u_rr (
        .valid     (req_valid),
        .ptr       (ptr_q),
        .hold      (hold),
        .grant     (req_ready),
        .grant_idx (grant_idx),
        .found     (accept)
    );

    // Operand select; the grant is one-hot so a plain priority loop suffices.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (req_ready[i]) begin
                sel_a  = req_a[i*W +: W];
                sel_b  = req_b[i*W +: W];
                sel_op = req_op[i];
            end
        end
    end

    // Pointer advance and issue register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            fu_valid <= 1'b0;
            fu_a     <= '0;
            fu_b     <= '0;
            fu_op    <= OP_ADD;
            tag_q    <= '0;
        end else begin
            fu_valid <= accept;
            if (accept) begin
                ptr_q <= (grant_idx == TW'(N - 1)) ? '0 : grant_idx + TW'(1);
                fu_a  <= sel_a;
                fu_b  <= sel_b;
                fu_op <= op_mode(sel_op);
                tag_q <= grant_idx;
            end
        end
    end

    // Tag pipe mirrors the unit; its last stage lines up with fu_res.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v_q <= '0;
            for (int s = 0; s < int'(LAT); s++) pipe_tag_q[s] <= '0;
        end else begin
            pipe_v_q[0]   <= fu_valid;
            pipe_tag_q[0] <= tag_q;
            for (int s = 1; s < int'(LAT); s++) begin
                pipe_v_q[s]   <= pipe_v_q[s-1];
                pipe_tag_q[s] <= pipe_tag_q[s-1];
            end
        end
    end

    // Decode the returning tag into a requester strobe.
    always_comb begin
        ret_onehot = '0;
        for (int i = 0; i < int'(N); i++) begin
            ret_onehot[i] = (pipe_tag_q[LAT-1] == TW'(i));
        end
    end

    // Result register; fu_res is only sampled when its tag slot is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= '0;
            res_data  <= '0;
            res_tag   <= '0;
        end else begin
            res_valid <= pipe_v_q[LAT-1] ? ret_onehot : '0;
            if (pipe_v_q[LAT-1]) begin
                res_data <= fu_res;
                res_tag  <= pipe_tag_q[LAT-1];
            end
        end
    end

    assign strobe = |res_valid;

    // In-flight count: issue adds, result strobe retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
        end else if (accept && !strobe) begin
            inflight_q <= inflight_q + CW'(1);
        end else if (!accept && strobe) begin
            inflight_q <= inflight_q - CW'(1);
        end
    end

    assign idle = (inflight_q == '0);

`ifdef FPADDSUB_ARB_PERF_EN
    logic conflict;

    // More than one bit set means contention for the unit.
    assign conflict = ((req_valid & (req_valid - N'(1))) != '0) && !hold;

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issue    <= '0;
            perf_conflict <= '0;
        end else begin
            if (accept && (perf_issue != '1)) perf_issue <= perf_issue + 32'd1;
            if (conflict && (perf_conflict != '1)) perf_conflict <= perf_conflict + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fpaddsub_issue_arbiter.sv
// tb_fpaddsub_issue_arbiter: directed self-checking bench, N=4, W=32, LAT=4.
// The FP unit is stood in for by an integer add/sub delay line of depth LAT.
module tb_fpaddsub_issue_arbiter;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int LAT = 4;
    localparam int TW  = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_op;
    logic           hold;
    logic           fu_valid;
    logic [W-1:0]   fu_a;
    logic [W-1:0]   fu_b;
    logic           fu_op;
    logic [W-1:0]   fu_res;
    logic [N-1:0]   res_valid;
    logic [W-1:0]   res_data;
    logic [TW-1:0]  res_tag;
    logic           idle;
`ifdef FPADDSUB_ARB_PERF_EN
    logic [31:0]    perf_issue;
    logic [31:0]    perf_conflict;
`endif

    fpaddsub_issue_arbiter #(
        .N   (N),
        .W   (W),
        .LAT (LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .hold      (hold),
        .fu_valid  (fu_valid),
        .fu_a      (fu_a),
        .fu_b      (fu_b),
        .fu_op     (fu_op),
        .fu_res    (fu_res),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_tag   (res_tag),
        .idle      (idle)
`ifdef FPADDSUB_ARB_PERF_EN
        ,
        .perf_issue    (perf_issue),
        .perf_conflict (perf_conflict)
`endif
    );

    always #5 clk = ~clk;

    // Stand-in FP unit: fixed LAT-cycle integer add/sub.
    logic [W-1:0] fu_pipe [LAT];
    always @(posedge clk) begin
        fu_pipe[0] <= fu_op ? fu_a - fu_b : fu_a + fu_b;
        for (int s = 1; s < LAT; s++) fu_pipe[s] <= fu_pipe[s-1];
    end
    assign fu_res = fu_pipe[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Result monitor.
    int           mon_tag  [$];
    logic [W-1:0] mon_data [$];
    logic [N-1:0] mon_hot  [$];
    int           mon_cyc  [$];
    always @(negedge clk) begin
        if (rst_n && res_valid != '0) begin
            mon_tag.push_back(int'(res_tag));
            mon_data.push_back(res_data);
            mon_hot.push_back(res_valid);
            mon_cyc.push_back(cyc);
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic mon_clear;
        mon_tag.delete();
        mon_data.delete();
        mon_hot.delete();
        mon_cyc.delete();
    endtask

    task automatic do_reset;
        req_valid = '0;
        hold      = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick;
        mon_clear();
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int w = 0;
        while (!idle && w < bound) begin
            tick;
            w++;
        end
        check_eq(tag, idle, 1'b1);
    endtask

    // Expected results per requester for the fixed operand set below.
    logic [W-1:0] exp_res [N] = '{32'h10, 32'h21, 32'h32, 32'h3D};

    task automatic load_operands;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = 32'h10 * (i + 1);
            req_b[i*W +: W] = i;
        end
        req_op = 4'b1000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int ready_seen;
        int idle_cyc;
        int occ;
        int occ_max;
        int last_cyc;

        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        hold      = 1'b0;

        // Reset state.
        #3;
        check_eq("rst_fu_valid", fu_valid, 1'b0);
        check_eq("rst_fu_a", fu_a, 32'h0);
        check_eq("rst_fu_op", fu_op, 1'b0);
        check_eq("rst_res_valid", res_valid, 4'b0);
        check_eq("rst_res_data", res_data, 32'h0);
        check_eq("rst_res_tag", res_tag, 2'd0);
        check_eq("rst_idle", idle, 1'b1);
        check_eq("rst_ready", req_ready, 4'b0);
        do_reset();

        // Single op from requester 2.
        req_a[2*W +: W] = 32'h3F80_0000;
        req_b[2*W +: W] = 32'h4000_0000;
        req_op          = 4'b0000;
        req_valid       = 4'b0100;
        #1;
        check_eq("t1_ready", req_ready, 4'b0100);
        tick;
        req_valid = '0;
        check_eq("t1_fu_valid", fu_valid, 1'b1);
        check_eq("t1_fu_a", fu_a, 32'h3F80_0000);
        check_eq("t1_fu_b", fu_b, 32'h4000_0000);
        check_eq("t1_fu_op", fu_op, 1'b0);
        check_eq("t1_idle1", idle, 1'b0);
        tick;
        check_eq("t1_fu_valid_drop", fu_valid, 1'b0);
        for (int k = 3; k <= 5; k++) begin
            tick;
            check_eq($sformatf("t1_quiet%0d", k), res_valid, 4'b0);
            check_eq($sformatf("t1_busy%0d", k), idle, 1'b0);
        end
        tick;
        check_eq("t1_res_valid", res_valid, 4'b0100);
        check_eq("t1_res_tag", res_tag, 2'd2);
        check_eq("t1_res_data", res_data, 32'h7F80_0000);
        check_eq("t1_idle6", idle, 1'b0);
        tick;
        check_eq("t1_res_valid_drop", res_valid, 4'b0);
        check_eq("t1_idle7", idle, 1'b1);

        // Four requesters, eight consecutive grants from pointer 0.
        do_reset();
        load_operands();
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1;
            check_eq($sformatf("t2_grant%0d", k), req_ready, 4'b1 << (k % 4));
            tick;
        end
        req_valid = '0;
        wait_idle("t2_drain", 30);
        check_eq("t2_count", mon_tag.size(), 8);
        for (int k = 0; k < 8 && k < mon_tag.size(); k++) begin
            check_eq($sformatf("t2_tag%0d", k), mon_tag[k], k % 4);
            check_eq($sformatf("t2_data%0d", k), mon_data[k], exp_res[k % 4]);
            check_eq($sformatf("t2_hot%0d", k), mon_hot[k], 4'b1 << (k % 4));
        end

        // hold with three ops in flight.
        do_reset();
        load_operands();
        req_valid = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq($sformatf("t3_grant%0d", k), req_ready, 4'b1 << k);
            tick;
        end
        hold       = 1'b1;
        req_valid  = 4'hF;
        ready_seen = 0;
        idle_cyc   = -1;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (req_ready != '0) ready_seen++;
            if (idle && idle_cyc < 0) idle_cyc = cyc;
            tick;
        end
        check_eq("t3_ready_held", ready_seen, 0);
        check_eq("t3_count", mon_tag.size(), 3);
        for (int k = 0; k < 3 && k < mon_tag.size(); k++) begin
            check_eq($sformatf("t3_tag%0d", k), mon_tag[k], k);
        end
        last_cyc = (mon_cyc.size() > 0) ? mon_cyc[mon_cyc.size()-1] : -100;
        check_eq("t3_idle_after_last", idle_cyc, last_cyc + 1);
        hold      = 1'b0;
        req_valid = '0;

        // Ten back-to-back ops: issue and retire overlap in steady state.
        do_reset();
        load_operands();
        occ_max = 0;
        for (int k = 0; k < 14; k++) begin
            req_valid = (k < 10) ? 4'hF : 4'h0;
            #1;
            occ = int'(dut.inflight_q);
            if (occ > occ_max) occ_max = occ;
            if (k >= 6 && k <= 10) check_eq($sformatf("t4_occ%0d", k), occ, LAT + 2);
            tick;
        end
        check_eq("t4_occ_max", occ_max, LAT + 2);
        wait_idle("t4_drain", 30);
        check_eq("t4_count", mon_tag.size(), 10);
        for (int k = 0; k < 10 && k < mon_tag.size(); k++) begin
            check_eq($sformatf("t4_tag%0d", k), mon_tag[k], k % 4);
        end

        // Reset with two ops in flight discards them.
        do_reset();
        load_operands();
        req_valid = 4'b0011;
        #1;
        check_eq("t5_grant0", req_ready, 4'b0001);
        tick;
        check_eq("t5_grant1", req_ready, 4'b0010);
        tick;
        req_valid = '0;
        tick;
        check_eq("t5_busy", idle, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t5_async_idle", idle, 1'b1);
        check_eq("t5_async_res", res_valid, 4'b0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (12) tick;
        check_eq("t5_no_results", mon_tag.size(), 0);
        req_valid = 4'b0110;
        #1;
        check_eq("t5_first_grant", req_ready, 4'b0010);
        tick;
        req_valid = '0;
        wait_idle("t5_drain", 30);

`ifdef FPADDSUB_ARB_PERF_EN
        // Five accepts, three of them in conflicting cycles.
        do_reset();
        check_eq("perf_rst_issue", perf_issue, 32'd0);
        check_eq("perf_rst_conflict", perf_conflict, 32'd0);
        begin
            logic [N-1:0] pv [5] = '{4'b0011, 4'b0011, 4'b0101, 4'b0001, 4'b1000};
            logic [N-1:0] pg [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b1000};
            for (int k = 0; k < 5; k++) begin
                req_valid = pv[k];
                #1;
                check_eq($sformatf("perf_grant%0d", k), req_ready, pg[k]);
                tick;
            end
        end
        req_valid = '0;
        tick;
        check_eq("perf_issue", perf_issue, 32'd5);
        check_eq("perf_conflict", perf_conflict, 32'd3);
        wait_idle("perf_drain", 30);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
